// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bundle: ID/EX/MEM hazard inputs and
// pipeline-register enables/clears driven back to the datapath.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       ifid_opcode;
    logic [3:0]       ifid_rs;
    logic [3:0]       ifid_rt;
    logic             ifid_use_rs;
    logic             ifid_use_rt;
    logic             idex_MemRead;
    logic [3:0]       idex_rd;
    logic             ex_redirect;
    logic             mem_req;
    logic             mem_ready;
    logic             pc_write;
    logic             wr_IFID;
    logic             IFIDclear;
    logic             wr_IDEX;
    logic             IDEXclear;
    logic             wr_EXMEM;
    logic             wr_MEMWB;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output ifid_opcode, ifid_rs, ifid_rt,
        output ifid_use_rs, ifid_use_rt,
        output idex_MemRead, idex_rd,
        output ex_redirect, mem_req, mem_ready,
        input  pc_write, wr_IFID, IFIDclear,
        input  wr_IDEX, IDEXclear,
        input  wr_EXMEM, wr_MEMWB,
        input  halted, stall_cnt
    );

    modport slave (
        input  ifid_opcode, ifid_rs, ifid_rt,
        input  ifid_use_rs, ifid_use_rt,
        input  idex_MemRead, idex_rd,
        input  ex_redirect, mem_req, mem_ready,
        output pc_write, wr_IFID, IFIDclear,
        output wr_IDEX, IDEXclear,
        output wr_EXMEM, wr_MEMWB,
        output halted, stall_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Optional stall counter enabled by HAZARD_STALL_CNT_EN.
module pipeline_hazard_ctrl #(
    parameter logic [3:0] HALT_OP      = 4'hF,
    parameter int         DRAIN_CYCLES = 3,
    parameter int         CNT_W        = 16
) (
    input logic              clk,
    input logic              reset,
    pipeline_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        MEMW   = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t     state, state_n;
    state_t     ret, ret_n, eff;
    logic [2:0] drain_cnt, cnt_n;
    logic       lu, mw;
    logic       pc_w, w_ifid, c_ifid, w_idex, c_idex;
    logic       w_exmem, w_memwb, hlt;

    assign lu = hz.idex_MemRead &
        ((hz.ifid_use_rs & (hz.ifid_rs == hz.idex_rd)) |
         (hz.ifid_use_rt & (hz.ifid_rt == hz.idex_rd)));
    assign mw = hz.mem_req & ~hz.mem_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            ret       <= RUN;
            drain_cnt <= 3'd0;
        end else begin
            state     <= state_n;
            ret       <= ret_n;
            drain_cnt <= cnt_n;
        end
    end

    // MEMW replays the rules of the state it interrupted.
    assign eff = (state == MEMW) ? ret : state;

    always_comb begin
        state_n = state;
        ret_n   = ret;
        cnt_n   = drain_cnt;
        pc_w    = 1'b1;
        w_ifid  = 1'b1;
        c_ifid  = 1'b0;
        w_idex  = 1'b1;
        c_idex  = 1'b0;
        w_exmem = 1'b1;
        w_memwb = 1'b1;
        hlt     = 1'b0;
        if (eff == HALTED) begin
            {pc_w, w_ifid, w_idex, w_exmem, w_memwb} = '0;
            hlt     = 1'b1;
            state_n = HALTED;
        end else if (mw) begin
            {pc_w, w_ifid, w_idex, w_exmem, w_memwb} = '0;
            state_n = MEMW;
            ret_n   = eff;
        end else if (hz.ex_redirect) begin
            c_ifid  = 1'b1;
            c_idex  = 1'b1;
            state_n = RUN;
            cnt_n   = 3'd0;
        end else if (eff == DRAIN) begin
            pc_w    = 1'b0;
            w_ifid  = 1'b0;
            c_idex  = 1'b1;
            cnt_n   = (drain_cnt == 3'd0) ? 3'd0 : drain_cnt - 3'd1;
            state_n = (drain_cnt <= 3'd1) ? HALTED : DRAIN;
        end else if (lu) begin
            pc_w    = 1'b0;
            w_ifid  = 1'b0;
            c_idex  = 1'b1;
            state_n = RUN;
        end else if (hz.ifid_opcode == HALT_OP) begin
            pc_w    = 1'b0;
            w_ifid  = 1'b0;
            c_idex  = 1'b1;
            state_n = DRAIN;
            cnt_n   = 3'(DRAIN_CYCLES - 1);
        end else begin
            state_n = RUN;
        end
        if (reset) begin
            {pc_w, w_ifid, w_idex, w_exmem, w_memwb, hlt} = '0;
            c_ifid = 1'b1;
            c_idex = 1'b1;
        end
    end

    assign hz.pc_write  = pc_w;
    assign hz.wr_IFID   = w_ifid;
    assign hz.IFIDclear = c_ifid;
    assign hz.wr_IDEX   = w_idex;
    assign hz.IDEXclear = c_idex;
    assign hz.wr_EXMEM  = w_exmem;
    assign hz.wr_MEMWB  = w_memwb;
    assign hz.halted    = hlt;

`ifdef HAZARD_STALL_CNT_EN
    logic [CNT_W-1:0] stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_q <= '0;
        else if (!pc_w && state != HALTED && stall_q != '1)
            stall_q <= stall_q + 1'b1;
    end

    assign hz.stall_cnt = stall_q;
`else
    assign hz.stall_cnt = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: expected output
// vectors queued at drive time, compared at the falling edge.
module tb_pipeline_hazard_ctrl;
    localparam int CW = 16;
    // {pc, wIFID, cIFID, wIDEX, cIDEX, wEXMEM, wMEMWB, halted}
    localparam logic [7:0] ADV = 8'b1101_0110;
    localparam logic [7:0] FRZ = 8'b0000_0000;
    localparam logic [7:0] BUB = 8'b0001_1110;
    localparam logic [7:0] RED = 8'b1111_1110;
    localparam logic [7:0] HLT = 8'b0000_0001;
    localparam logic [7:0] RST = 8'b0010_1000;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    logic [7:0] sb[$];

    pipeline_hazard_ctrl_if #(.CNT_W(CW)) bus ();

    pipeline_hazard_ctrl #(
        .HALT_OP(4'hF),
        .DRAIN_CYCLES(3),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .hz(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, needed finish");
        $fatal(1);
    end

    function automatic logic [7:0] outs();
        return {bus.pc_write, bus.wr_IFID, bus.IFIDclear,
                bus.wr_IDEX, bus.IDEXclear, bus.wr_EXMEM,
                bus.wr_MEMWB, bus.halted};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.ifid_opcode  = 4'h0;
        bus.ifid_rs      = 4'h0;
        bus.ifid_rt      = 4'h0;
        bus.ifid_use_rs  = 1'b0;
        bus.ifid_use_rt  = 1'b0;
        bus.idex_MemRead = 1'b0;
        bus.idex_rd      = 4'h0;
        bus.ex_redirect  = 1'b0;
        bus.mem_req      = 1'b0;
        bus.mem_ready    = 1'b0;
    endtask

    task automatic step(input string tag, input logic [7:0] e);
        logic [7:0] x;
        sb.push_back(e);
        @(negedge clk);
        x = sb.pop_front();
        chk(tag, {24'd0, outs()}, {24'd0, x});
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string tag, input int n);
`ifdef HAZARD_STALL_CNT_EN
        chk(tag, {16'd0, bus.stall_cnt}, n);
`else
        chk(tag, {16'd0, bus.stall_cnt}, 0);
`endif
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        #1;
        chk("rst_out", {24'd0, outs()}, {24'd0, RST});
        chk_cnt("rst_cnt", 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        step("adv0", ADV);

        bus.idex_MemRead = 1'b1;
        bus.idex_rd      = 4'h3;
        bus.ifid_rs      = 4'h3;
        bus.ifid_use_rs  = 1'b1;
        step("lu_rs", BUB);
        bus.idex_MemRead = 1'b0;
        step("lu_after", ADV);
        bus.idex_MemRead = 1'b1;
        bus.ifid_use_rs  = 1'b0;
        step("lu_nouse", ADV);
        bus.ifid_rs      = 4'h0;
        bus.ifid_rt      = 4'h3;
        bus.ifid_use_rt  = 1'b1;
        step("lu_rt", BUB);
        bus.ifid_rt      = 4'h5;
        step("lu_rt_ne", ADV);
        bus.ifid_rt      = 4'h3;
        bus.ex_redirect  = 1'b1;
        step("redir_lu", RED);
        idle();
        step("redir_after", ADV);
        chk_cnt("cnt_lu", 2);

        do_reset();
        bus.mem_req = 1'b1;
        repeat (4) step("memw", FRZ);
        bus.mem_ready = 1'b1;
        step("memw_done", ADV);
        idle();
        chk_cnt("cnt_memw", 4);

        do_reset();
        bus.ifid_opcode = 4'hF;
        step("halt_acc", BUB);
        step("drain1", BUB);
        step("drain2", BUB);
        step("halted4", HLT);
        bus.ex_redirect = 1'b1;
        bus.mem_req     = 1'b1;
        step("halted5", HLT);
        idle();
        step("halted6", HLT);
        chk_cnt("cnt_halt", 3);

        do_reset();
        bus.ifid_opcode = 4'hF;
        step("hc_acc", BUB);
        step("hc_drain1", BUB);
        bus.ex_redirect = 1'b1;
        step("hc_redir", RED);
        idle();
        step("hc_run1", ADV);
        step("hc_run2", ADV);

        do_reset();
        bus.ifid_opcode = 4'hF;
        step("dw_acc", BUB);
        bus.mem_req = 1'b1;
        step("dw_frz1", FRZ);
        step("dw_frz2", FRZ);
        bus.mem_ready = 1'b1;
        step("dw_drain1", BUB);
        bus.mem_req   = 1'b0;
        bus.mem_ready = 1'b0;
        step("dw_drain2", BUB);
        step("dw_halted", HLT);

        do_reset();
        bus.mem_req = 1'b1;
        step("ar_frz1", FRZ);
        step("ar_frz2", FRZ);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_async", {24'd0, outs()}, {24'd0, RST});
        @(posedge clk);
        #1;
        idle();
        reset = 1'b0;
        step("ar_adv", ADV);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
